// File: rtl/sim_monitor_pkg.sv
// sim_monitor_pkg: shared types and defaults for the store-bus pass/fail monitor.
// Provides the monitor FSM state enum, default limits and an index-width helper.
package sim_monitor_pkg;

  typedef enum logic [1:0] {
    MON_RUN,
    MON_HOLD,
    MON_DONE
  } mon_state_t;

  localparam int DEF_TIMEOUT = 512;
  localparam int DEF_HOLDOFF = 10;

  // Width needed to index n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sim_watchdog.sv
// sim_watchdog: CW-bit saturating cycle counter with enable, freeze and expiry flag.
// in: clk reset(async, active-low) en freeze; out: cnt, expire (cnt at LIMIT-1)
module sim_watchdog #(
  parameter int CW    = 16,
  parameter int LIMIT = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          freeze,
  output logic [CW-1:0] cnt,
  output logic          expire
);

  // A limit wider than the counter can never be reached; the
  // counter then just saturates instead of wrapping into a false expiry.
  localparam bit REACH =
    (CW >= 31) || (LIMIT <= (2 ** CW));
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic sat;

  assign sat    = &cnt;
  assign expire = REACH && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (en && !freeze && !expire && !sat) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sim_pass_monitor.sv
// sim_pass_monitor: compares every store against NUM_CHK signatures, runs a watchdog, flags pass/fail/halt.
// in: clk reset memwrite dataadr writedata chk_en chk_adr chk_data ordered; out: done pass fail pass_idx halt cycles
module sim_pass_monitor
  import sim_monitor_pkg::*;
#(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int NUM_CHK = 4,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int CW      = 16,
  localparam int IW     = idx_w(NUM_CHK)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            memwrite,
  input  logic [AW-1:0]         dataadr,
  input  logic [DW-1:0]         writedata,
  input  logic [NUM_CHK-1:0]    chk_en,
  input  logic [NUM_CHK*AW-1:0] chk_adr,
  input  logic [NUM_CHK*DW-1:0] chk_data,
  input  logic                  ordered,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [IW-1:0]         pass_idx,
  output logic                  halt,
  output logic [CW-1:0]         cycles
);

  localparam int PW = idx_w(NUM_CHK + 1);
  localparam int HW = idx_w(HOLDOFF);
  localparam logic [HW-1:0] HLAST =
    HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  if (NUM_CHK < 1 || NUM_CHK > 16) begin : g_bad_num_chk
    $error("sim_pass_monitor: NUM_CHK must be 1..16");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("sim_pass_monitor: TIMEOUT must be >= 2");
  end
  if (CW < 31 && (2 ** CW) < TIMEOUT) begin : g_bad_cw
    $error("sim_pass_monitor: CW too narrow for TIMEOUT");
  end

  mon_state_t state, state_n;

  logic [PW-1:0] seq_ptr, ptr_n;
  logic [HW-1:0] hold_cnt, hcnt_n;
  logic          done_n, pass_n, fail_n, halt_n;
  logic [IW-1:0] idx_n;

  logic [NUM_CHK-1:0] hit;
  logic               st;
  logic [IW-1:0]      any_idx;
  logic [IW-1:0]      cur;
  logic               cur_ok;
  logic               more;
  logic               seq_hit;
  logic               win;
  logic [IW-1:0]      win_idx;
  logic               expire;
  logic               run;

  assign st  = |memwrite;
  assign run = (state == MON_RUN);

  for (genvar i = 0; i < NUM_CHK; i++) begin : g_cmp
    assign hit[i] = st & chk_en[i]
      & (dataadr == chk_adr[i*AW +: AW])
      & (writedata == chk_data[i*DW +: DW]);
  end

  // cur is the slot the ordered sequence waits on: the first
  // enabled slot at or after seq_ptr. more says a later enabled
  // slot still has to hit before the sequence is complete.
  always_comb begin
    any_idx = '0;
    for (int i = NUM_CHK - 1; i >= 0; i--) begin
      if (hit[i]) any_idx = IW'(i);
    end
    cur_ok = 1'b0;
    cur    = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (!cur_ok && chk_en[i] && PW'(i) >= seq_ptr) begin
        cur_ok = 1'b1;
        cur    = IW'(i);
      end
    end
    more = 1'b0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (chk_en[i] && IW'(i) > cur) more = 1'b1;
    end
    seq_hit = cur_ok & hit[cur];
    win     = ordered ? (seq_hit & ~more) : (|hit);
    win_idx = ordered ? cur : any_idx;
  end

  // A winning hit freezes the count on the edge it is sampled,
  // so cycles reports the cycle the matching store appeared.
  sim_watchdog #(
    .CW    (CW),
    .LIMIT (TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .en     (run),
    .freeze (win),
    .cnt    (cycles),
    .expire (expire)
  );

  always_comb begin
    state_n = state;
    ptr_n   = seq_ptr;
    hcnt_n  = hold_cnt;
    done_n  = done;
    pass_n  = pass;
    fail_n  = fail;
    halt_n  = halt;
    idx_n   = pass_idx;
    unique case (state)
      MON_RUN: begin
        if (ordered && seq_hit && more) begin
          ptr_n = PW'(cur) + PW'(1);
        end
        // A hit on the expiry edge still counts as a pass.
        if (win) begin
          pass_n = 1'b1;
          done_n = 1'b1;
          idx_n  = win_idx;
          if (HOLDOFF == 0) begin
            halt_n  = 1'b1;
            state_n = MON_DONE;
          end else begin
            state_n = MON_HOLD;
          end
        end else if (expire) begin
          fail_n  = 1'b1;
          done_n  = 1'b1;
          halt_n  = 1'b1;
          state_n = MON_DONE;
        end
      end
      MON_HOLD: begin
        hcnt_n = hold_cnt + HW'(1);
        if (hold_cnt == HLAST) begin
          halt_n  = 1'b1;
          state_n = MON_DONE;
        end
      end
      MON_DONE: begin
        state_n = MON_DONE;
      end
      default: begin
        state_n = MON_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= MON_RUN;
      seq_ptr  <= '0;
      hold_cnt <= '0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      halt     <= 1'b0;
      pass_idx <= '0;
    end else begin
      state    <= state_n;
      seq_ptr  <= ptr_n;
      hold_cnt <= hcnt_n;
      done     <= done_n;
      pass     <= pass_n;
      fail     <= fail_n;
      halt     <= halt_n;
      pass_idx <= idx_n;
    end
  end

endmodule

// File: tb/tb_sim_pass_monitor.sv
// tb_sim_pass_monitor: scoreboard bench for sim_pass_monitor (HOLDOFF=10 and HOLDOFF=0 builds).
// Stimulus queues expected reset/done/halt events; a monitor pops them as the DUT shows them.
module tb_sim_pass_monitor;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NC = 4;
  localparam int CW = 16;

  localparam int K_RST  = 0;
  localparam int K_DONE = 1;
  localparam int K_HALT = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       memwrite = '0;
  logic [AW-1:0]    dataadr = '0;
  logic [DW-1:0]    writedata = '0;
  logic [NC-1:0]    chk_en = '0;
  logic [NC*AW-1:0] chk_adr = '0;
  logic [NC*DW-1:0] chk_data = '0;
  logic             ordered = 1'b0;
  logic             sel = 1'b0;

  logic          d_done, d_pass, d_fail, d_halt;
  logic [1:0]    d_idx;
  logic [CW-1:0] d_cyc;
  logic          z_done, z_pass, z_fail, z_halt;
  logic [1:0]    z_idx;
  logic [CW-1:0] z_cyc;

  logic          m_done, m_pass, m_fail, m_halt;
  logic [1:0]    m_idx;
  logic [CW-1:0] m_cyc;

  always #5 clk = ~clk;

  sim_pass_monitor #(
    .AW(AW), .DW(DW), .NUM_CHK(NC),
    .TIMEOUT(512), .HOLDOFF(10), .CW(CW)
  ) u_dut (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .chk_en(chk_en), .chk_adr(chk_adr), .chk_data(chk_data),
    .ordered(ordered), .done(d_done), .pass(d_pass),
    .fail(d_fail), .pass_idx(d_idx), .halt(d_halt),
    .cycles(d_cyc)
  );

  sim_pass_monitor #(
    .AW(AW), .DW(DW), .NUM_CHK(NC),
    .TIMEOUT(512), .HOLDOFF(0), .CW(CW)
  ) u_dut0 (
    .clk(clk), .reset(reset), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .chk_en(chk_en), .chk_adr(chk_adr), .chk_data(chk_data),
    .ordered(ordered), .done(z_done), .pass(z_pass),
    .fail(z_fail), .pass_idx(z_idx), .halt(z_halt),
    .cycles(z_cyc)
  );

  assign m_done = sel ? z_done : d_done;
  assign m_pass = sel ? z_pass : d_pass;
  assign m_fail = sel ? z_fail : d_fail;
  assign m_halt = sel ? z_halt : d_halt;
  assign m_idx  = sel ? z_idx : d_idx;
  assign m_cyc  = sel ? z_cyc : d_cyc;

  typedef struct {
    int k;
    int p;
    int f;
    int i;
    int c;
    int dh;
    int lat;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;
  int tc = 0;

  function automatic exp_t mk(input int k, input int p,
                              input int f, input int i,
                              input int c, input int dh,
                              input int lat);
    exp_t e;
    e.k = k; e.p = p; e.f = f; e.i = i;
    e.c = c; e.dh = dh; e.lat = lat;
    return e;
  endfunction

  task automatic chk_evt(input int kind, input int lat);
    exp_t e;
    exp_t a;
    a = mk(kind, int'(m_pass), int'(m_fail), int'(m_idx),
           int'(m_cyc), int'({m_done, m_halt}), lat);
    compared++;
    if (q.size() == 0) begin
      mismatched++;
      $display("FAIL unexpected_evt: got kind=%0d with nothing expected",
               kind);
      return;
    end
    e = q.pop_front();
    if (e.k != a.k || e.p != a.p || e.f != a.f || e.i != a.i ||
        e.c != a.c || e.dh != a.dh || e.lat != a.lat) begin
      mismatched++;
      $display({"FAIL evt%0d: got k=%0d p=%0d f=%0d i=%0d c=%0d dh=%0d ",
                "lat=%0d want k=%0d p=%0d f=%0d i=%0d c=%0d dh=%0d lat=%0d"},
               compared, a.k, a.p, a.f, a.i, a.c, a.dh, a.lat,
               e.k, e.p, e.f, e.i, e.c, e.dh, e.lat);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    logic p_rst;
    logic p_done;
    logic p_halt;
    int   since;
    p_rst = 1'b1; p_done = 1'b0; p_halt = 1'b0; since = 0;
    forever begin
      @(posedge clk);
      #1;
      if (p_rst && !reset) begin
        chk_evt(K_RST, 0);
      end else if (reset) begin
        if (m_done && !p_done) begin
          since = 0;
          chk_evt(K_DONE, 0);
        end else begin
          since++;
        end
        if (m_halt && !p_halt) chk_evt(K_HALT, since);
      end
      p_rst  = reset;
      p_done = m_done;
      p_halt = m_halt;
    end
  end

  task automatic step();
    @(negedge clk);
    tc++;
  endtask

  task automatic wait_to(input int n);
    while (tc < n) step();
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d,
                       input logic [1:0] mw);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    step();
    memwrite = '0;
  endtask

  task automatic do_reset(input logic use0);
    @(negedge clk);
    memwrite = '0;
    reset = 1'b0;
    sel = use0;
    q.push_back(mk(K_RST, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    tc = 0;
  endtask

  task automatic set_slot(input int i, input logic [63:0] a,
                          input logic [63:0] d);
    chk_adr[i*AW +: AW]  = a;
    chk_data[i*DW +: DW] = d;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      compared += q.size();
      mismatched += q.size();
      $display("FAIL drain: %0d expected events never seen", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Power-on reset, then T1: any-mode single slot.
    q.push_back(mk(K_RST, 0, 0, 0, 0, 0, 0));
    set_slot(0, 64'd100, 64'd7);
    chk_en = 4'b0001;
    ordered = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tc = 0;
    q.push_back(mk(K_DONE, 1, 0, 0, 30, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 0, 30, 3, 10));
    wait_to(30);
    store(64'd100, 64'd7, 2'b10);
    drain(40);

    // T2: near misses only, watchdog fires.
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 0, 1, 0, 511, 3, 0));
    q.push_back(mk(K_HALT, 0, 1, 0, 511, 3, 0));
    wait_to(5);
    store(64'd100, 64'd6, 2'b01);
    store(64'd101, 64'd7, 2'b01);
    drain(600);

    // T3a: ordered, out-of-order first store is ignored.
    set_slot(0, 64'd80, 64'd1);
    set_slot(1, 64'd128, 64'd7);
    chk_en = 4'b0011;
    ordered = 1'b1;
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 1, 12, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 1, 12, 3, 10));
    wait_to(10);
    store(64'd128, 64'd7, 2'b01);
    store(64'd80, 64'd1, 2'b01);
    store(64'd128, 64'd7, 2'b01);
    drain(40);

    // T3b: same stream, any-mode passes on first store.
    ordered = 1'b0;
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 1, 10, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 1, 10, 3, 10));
    wait_to(10);
    store(64'd128, 64'd7, 2'b01);
    store(64'd80, 64'd1, 2'b01);
    store(64'd128, 64'd7, 2'b01);
    drain(40);

    // T3c: ordered with disabled slots skipped (slots 1 then 3).
    set_slot(3, 64'd200, 64'd9);
    chk_en = 4'b1010;
    ordered = 1'b1;
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 3, 8, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 3, 8, 3, 10));
    wait_to(5);
    store(64'd80, 64'd1, 2'b11);
    store(64'd200, 64'd9, 2'b11);
    store(64'd128, 64'd7, 2'b11);
    store(64'd200, 64'd9, 2'b11);
    drain(40);

    // T4: hit on the expiry edge, pass wins.
    set_slot(0, 64'd100, 64'd7);
    chk_en = 4'b0001;
    ordered = 1'b0;
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 0, 511, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 0, 511, 3, 10));
    wait_to(511);
    store(64'd100, 64'd7, 2'b01);
    drain(40);

    // T5: reset during HOLD, no halt, then a clean re-run.
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 0, 20, 2, 0));
    wait_to(20);
    store(64'd100, 64'd7, 2'b01);
    repeat (3) @(negedge clk);
    do_reset(1'b0);
    q.push_back(mk(K_DONE, 1, 0, 0, 25, 2, 0));
    q.push_back(mk(K_HALT, 1, 0, 0, 25, 3, 10));
    wait_to(25);
    store(64'd100, 64'd7, 2'b01);
    drain(40);

    // T6: HOLDOFF=0 build, only slot 2 enabled.
    set_slot(2, 64'd64, 64'd3);
    chk_en = 4'b0100;
    do_reset(1'b1);
    q.push_back(mk(K_DONE, 1, 0, 2, 15, 3, 0));
    q.push_back(mk(K_HALT, 1, 0, 2, 15, 3, 0));
    wait_to(15);
    store(64'd64, 64'd3, 2'b11);
    drain(40);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
